// File: rtl/mem_access_if.sv
// mem_access_if: pipeline-side bundle for the MIPS MEM stage.
// Carries the EX/MEM inputs, debug controls and the MEM/WB register outputs.
// The master modport is the pipeline/debugger side; slave is mem_access_unit.
interface mem_access_if #(
    parameter int ADDR_W = 10,
    parameter int WB_W   = 5
);
    logic              stop_debug;
    logic              in_valid;
    logic [WB_W-1:0]   in_wb;
    logic              in_mem_rd;
    logic              in_mem_wr;
    logic [1:0]        in_size;
    logic              in_unsigned;
    logic [31:0]       in_alu_result;
    logic [31:0]       in_reg_b;
    logic [4:0]        in_wreg;
    logic              debug_on;
    logic [ADDR_W-1:0] debug_addr;

    logic              stall;
    logic              out_valid;
    logic [WB_W-1:0]   out_wb;
    logic [31:0]       out_alu_result;
    logic [4:0]        out_wreg;
    logic [31:0]       out_load_data;
    logic              misalign;
    logic [31:0]       out_mem_debug;

    modport master (
        output stop_debug, in_valid, in_wb, in_mem_rd, in_mem_wr, in_size,
               in_unsigned, in_alu_result, in_reg_b, in_wreg, debug_on, debug_addr,
        input  stall, out_valid, out_wb, out_alu_result, out_wreg, out_load_data,
               misalign, out_mem_debug
    );

    modport slave (
        input  stop_debug, in_valid, in_wb, in_mem_rd, in_mem_wr, in_size,
               in_unsigned, in_alu_result, in_reg_b, in_wreg, debug_on, debug_addr,
        output stall, out_valid, out_wb, out_alu_result, out_wreg, out_load_data,
               misalign, out_mem_debug
    );
endinterface

// File: rtl/mem_access_unit.sv
// mem_access_unit: MEM stage of the MIPS pipeline.
// Holds a 2**ADDR_W x 32 data memory, performs byte/half/word stores and
// sign/zero-extended loads with a READ_LAT-cycle load latency (1..4), and
// registers the MEM/WB boundary. Loads back-pressure upstream through stall.
// Optional feature: define MEM_ACCESS_MISALIGN_TRAP_EN to trap misaligned
// half/word accesses instead of silently forcing alignment.
module mem_access_unit #(
    parameter int ADDR_W   = 10,
    parameter int WB_W     = 5,
    parameter int READ_LAT = 2
) (
    input  logic        clk,
    input  logic        rst,
    mem_access_if.slave bus
);
    localparam int         DEPTH    = 1 << ADDR_W;
    localparam bit         MULTI    = (READ_LAT > 1);
    localparam logic [1:0] CNT_INIT = 2'(READ_LAT - 1);

    typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

    state_t            state;
    logic [1:0]        cnt;
    logic [31:0]       mem [DEPTH];

    logic              stall;
    logic              accept;
    logic              isLoad;
    logic              isStore;
    logic              misal;
    logic              memWe;
    logic [ADDR_W-1:0] idx;
    logic [1:0]        lane;
    logic [3:0]        wrMask;
    logic [31:0]       wrData;

    // load context captured at acceptance (data only, never reset)
    logic [ADDR_W-1:0] ldIdx_p1;
    logic [1:0]        ldLane_p1;
    logic [1:0]        ldSize_p1;
    logic              ldUns_p1;
    logic [WB_W-1:0]   ldWb_p1;
    logic [31:0]       ldAlu_p1;
    logic [4:0]        ldWreg_p1;

    logic [31:0]       rdWord;
    logic [1:0]        rdLane;
    logic [1:0]        rdSize;
    logic              rdUns;
    logic [31:0]       ldResult;

    // MEM/WB register
    logic              outValid;
    logic [WB_W-1:0]   outWb;
    logic [31:0]       outAluResult;
    logic [4:0]        outWreg;
    logic [31:0]       outLoadData;
    logic              outMisalign;
    logic [31:0]       dbgWord;

    // Pick the addressed lane(s) and extend to 32 bits; size 11 behaves as word.
    function automatic logic [31:0] extendLoad(input logic [31:0] word,
                                               input logic [1:0]  laneSel,
                                               input logic [1:0]  size,
                                               input logic        zeroExt);
        logic [31:0]        shifted;
        logic signed [7:0]  sByte;
        logic signed [15:0] sHalf;
        shifted = word >> {laneSel, 3'b000};
        sByte   = shifted[7:0];
        sHalf   = shifted[15:0];
        case (size)
            2'b00: begin
                if (zeroExt) return {24'd0, shifted[7:0]};
                return 32'(sByte);
            end
            2'b01: begin
                if (zeroExt) return {16'd0, shifted[15:0]};
                return 32'(sHalf);
            end
            default: return word;
        endcase
    endfunction

    assign stall   = (state != IDLE);
    assign accept  = bus.in_valid && !stall && !bus.stop_debug;
    assign isStore = bus.in_mem_wr;
    assign isLoad  = bus.in_mem_rd && !bus.in_mem_wr;
    assign idx     = bus.in_alu_result[ADDR_W+1:2];
    assign memWe   = accept && isStore && !bus.debug_on && !misal;

    // Lane alignment and misalignment detection for the incoming access.
    always_comb begin
        lane  = bus.in_alu_result[1:0];
        misal = 1'b0;
        case (bus.in_size)
            2'b00: ;
            2'b01: begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                misal = lane[0];
`endif
                lane[0] = 1'b0;
            end
            default: begin
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
                misal = (lane != 2'b00);
`endif
                lane = 2'b00;
            end
        endcase
    end

    // Byte-lane write enables and replicated store data from the low bits of reg_b.
    always_comb begin
        case (bus.in_size)
            2'b00: begin
                wrMask = 4'b0001 << lane;
                wrData = {4{bus.in_reg_b[7:0]}};
            end
            2'b01: begin
                wrMask = lane[1] ? 4'b1100 : 4'b0011;
                wrData = {2{bus.in_reg_b[15:0]}};
            end
            default: begin
                wrMask = 4'b1111;
                wrData = bus.in_reg_b;
            end
        endcase
    end

    // Data memory write port; contents survive reset.
    always_ff @(posedge clk) begin
        if (memWe) begin
            for (int k = 0; k < 4; k++) begin
                if (wrMask[k]) mem[idx][8*k +: 8] <= wrData[8*k +: 8];
            end
        end
    end

    // Read side: captured load context in DONE, live inputs for single-cycle loads.
    always_comb begin
        if (state == DONE) begin
            rdWord = mem[ldIdx_p1];
            rdLane = ldLane_p1;
            rdSize = ldSize_p1;
            rdUns  = ldUns_p1;
        end else begin
            rdWord = mem[idx];
            rdLane = lane;
            rdSize = bus.in_size;
            rdUns  = bus.in_unsigned;
        end
        ldResult = extendLoad(rdWord, rdLane, rdSize, rdUns);
    end

    // ---- stage boundary: EX/MEM -> load context ----
    // Capture the load context on acceptance so upstream may move on later.
    always_ff @(posedge clk) begin
        if (accept && isLoad) begin
            ldIdx_p1  <= idx;
            ldLane_p1 <= lane;
            ldSize_p1 <= bus.in_size;
            ldUns_p1  <= bus.in_unsigned;
            ldWb_p1   <= bus.in_wb;
            ldAlu_p1  <= bus.in_alu_result;
            ldWreg_p1 <= bus.in_wreg;
        end
    end

    // ---- stage boundary: MEM -> MEM/WB ----
    // Load FSM and MEM/WB register. cnt counts remaining stall cycles; DONE is
    // the last of them, so WAIT hands over when one cycle is left.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            outValid     <= 1'b0;
            outWb        <= '0;
            outAluResult <= '0;
            outWreg      <= '0;
            outLoadData  <= '0;
            outMisalign  <= 1'b0;
        end else if (!bus.stop_debug) begin
            case (state)
                IDLE: begin
                    outAluResult <= bus.in_alu_result;
                    outWreg      <= bus.in_wreg;
                    if (MULTI && bus.in_valid && isLoad && !misal) begin
                        // load in flight: present a bubble until DONE
                        outValid    <= 1'b0;
                        outWb       <= '0;
                        outLoadData <= '0;
                        outMisalign <= 1'b0;
                        cnt         <= CNT_INIT;
                        state       <= (READ_LAT == 2) ? DONE : WAIT;
                    end else begin
                        outValid    <= bus.in_valid;
                        outWb       <= (bus.in_valid && !misal) ? bus.in_wb : '0;
                        outLoadData <= (bus.in_valid && isLoad && !misal) ? ldResult : '0;
                        outMisalign <= bus.in_valid && misal;
                    end
                end
                WAIT: begin
                    outValid <= 1'b0;
                    cnt      <= cnt - 2'd1;
                    if (cnt == 2'd2) state <= DONE;
                end
                DONE: begin
                    outValid     <= 1'b1;
                    outWb        <= ldWb_p1;
                    outAluResult <= ldAlu_p1;
                    outWreg      <= ldWreg_p1;
                    outLoadData  <= ldResult;
                    outMisalign  <= 1'b0;
                    cnt          <= '0;
                    state        <= IDLE;
                end
                default: begin
                    cnt   <= '0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Debug read port, refreshed every non-frozen cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            dbgWord <= '0;
        end else if (!bus.stop_debug) begin
            dbgWord <= mem[bus.debug_addr];
        end
    end

    assign bus.stall          = stall;
    assign bus.out_valid      = outValid;
    assign bus.out_wb         = outWb;
    assign bus.out_alu_result = outAluResult;
    assign bus.out_wreg       = outWreg;
    assign bus.out_load_data  = outLoadData;
    assign bus.misalign       = outMisalign;
    assign bus.out_mem_debug  = dbgWord;
endmodule

// File: tb/tb_mem_access_unit.sv
// tb_mem_access_unit: directed bench for mem_access_unit.
// dut2 runs with READ_LAT = 2, dut3 with READ_LAT = 3 (freeze and reset-in-WAIT).
module tb_mem_access_unit;
    logic clk = 1'b0;
    logic rst2;
    logic rst3;
    int   nChecks = 0;
    int   nErrors = 0;

    always #5 clk = ~clk;

    mem_access_if #(.ADDR_W(10), .WB_W(5)) bus2 ();
    mem_access_if #(.ADDR_W(10), .WB_W(5)) bus3 ();

    mem_access_unit #(.ADDR_W(10), .WB_W(5), .READ_LAT(2)) dut2 (
        .clk(clk), .rst(rst2), .bus(bus2.slave)
    );
    mem_access_unit #(.ADDR_W(10), .WB_W(5), .READ_LAT(3)) dut3 (
        .clk(clk), .rst(rst3), .bus(bus3.slave)
    );

    task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nChecks++;
        if (got !== exp) begin
            nErrors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input bit sel, input logic v, input logic rd, input logic wr,
                         input logic [1:0] sz, input logic uns, input logic [31:0] a,
                         input logic [31:0] b, input logic [4:0] wreg, input logic [4:0] wb);
        if (sel) begin
            bus3.in_valid = v; bus3.in_mem_rd = rd; bus3.in_mem_wr = wr;
            bus3.in_size = sz; bus3.in_unsigned = uns; bus3.in_alu_result = a;
            bus3.in_reg_b = b; bus3.in_wreg = wreg; bus3.in_wb = wb;
        end else begin
            bus2.in_valid = v; bus2.in_mem_rd = rd; bus2.in_mem_wr = wr;
            bus2.in_size = sz; bus2.in_unsigned = uns; bus2.in_alu_result = a;
            bus2.in_reg_b = b; bus2.in_wreg = wreg; bus2.in_wb = wb;
        end
    endtask

    task automatic bubble(input bit sel);
        drive(sel, 1'b0, 1'b0, 1'b0, 2'b00, 1'b0, 32'd0, 32'd0, 5'd0, 5'd0);
    endtask

    task automatic store2(input logic [1:0] sz, input logic [31:0] a, input logic [31:0] b);
        drive(1'b0, 1'b1, 1'b0, 1'b1, sz, 1'b0, a, b, 5'd2, 5'h03);
        tick();
        bubble(1'b0);
    endtask

    // Load on dut2: one stall cycle, result two cycles after acceptance.
    task automatic load2(input string tag, input logic [1:0] sz, input logic uns,
                         input logic [31:0] a, input logic [31:0] expData);
        drive(1'b0, 1'b1, 1'b1, 1'b0, sz, uns, a, 32'd0, 5'd9, 5'h0A);
        tick();
        bubble(1'b0);
        checkVal({tag, "_stall"}, 32'(bus2.stall), 32'd1);
        checkVal({tag, "_vld_early"}, 32'(bus2.out_valid), 32'd0);
        tick();
        checkVal({tag, "_stall_low"}, 32'(bus2.stall), 32'd0);
        checkVal({tag, "_vld"}, 32'(bus2.out_valid), 32'd1);
        checkVal({tag, "_data"}, bus2.out_load_data, expData);
        checkVal({tag, "_wreg"}, 32'(bus2.out_wreg), 32'd9);
        checkVal({tag, "_wb"}, 32'(bus2.out_wb), 32'h0A);
    endtask

    initial begin
        rst2 = 1'b1;
        rst3 = 1'b1;
        bubble(1'b0);
        bubble(1'b1);
        bus2.stop_debug = 1'b0; bus2.debug_on = 1'b0; bus2.debug_addr = '0;
        bus3.stop_debug = 1'b0; bus3.debug_on = 1'b0; bus3.debug_addr = '0;
        repeat (2) tick();

        // reset state
        checkVal("rst_stall", 32'(bus2.stall), 32'd0);
        checkVal("rst_valid", 32'(bus2.out_valid), 32'd0);
        checkVal("rst_wb", 32'(bus2.out_wb), 32'd0);
        checkVal("rst_alu", bus2.out_alu_result, 32'd0);
        checkVal("rst_wreg", 32'(bus2.out_wreg), 32'd0);
        checkVal("rst_load", bus2.out_load_data, 32'd0);
        checkVal("rst_misalign", 32'(bus2.misalign), 32'd0);
        checkVal("rst_dbg", bus2.out_mem_debug, 32'd0);
        rst2 = 1'b0;
        rst3 = 1'b0;
        tick();

        // store word, then a byte into lane 2 (only the low byte of reg_b lands)
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 5'd3, 5'h1F);
        tick();
        checkVal("stw_valid", 32'(bus2.out_valid), 32'd1);
        checkVal("stw_wb", 32'(bus2.out_wb), 32'h1F);
        checkVal("stw_alu", bus2.out_alu_result, 32'h10);
        checkVal("stw_wreg", 32'(bus2.out_wreg), 32'd3);
        checkVal("stw_stall", 32'(bus2.stall), 32'd0);
        store2(2'b00, 32'h12, 32'h123456AB);
        tick();
        checkVal("bubble_valid", 32'(bus2.out_valid), 32'd0);
        checkVal("bubble_wb", 32'(bus2.out_wb), 32'd0);

        load2("ldw", 2'b10, 1'b0, 32'h10, 32'h11AB3344);
        load2("ldsb", 2'b00, 1'b0, 32'h12, 32'hFFFFFFAB);
        load2("lduh", 2'b01, 1'b1, 32'h12, 32'h000011AB);
        load2("ldub", 2'b00, 1'b1, 32'h12, 32'h000000AB);
        load2("ldsh_lo", 2'b01, 1'b0, 32'h10, 32'h00003344);
        load2("ldw_wrap", 2'b10, 1'b0, 32'h1010, 32'h11AB3344);

        // store immediately followed by a load of the same word
        store2(2'b10, 32'h30, 32'h80017FFF);
        load2("ldsh_neg", 2'b01, 1'b0, 32'h32, 32'hFFFF8001);
        load2("ldsh_pos", 2'b01, 1'b0, 32'h30, 32'h00007FFF);
        store2(2'b01, 32'h32, 32'h0000BEEF);
        load2("sth_hi", 2'b10, 1'b0, 32'h30, 32'hBEEF7FFF);

        // load+store together: the store wins, no stall, load data is zero
        drive(1'b0, 1'b1, 1'b1, 1'b1, 2'b10, 1'b0, 32'h50, 32'h00000077, 5'd4, 5'h05);
        tick();
        bubble(1'b0);
        checkVal("rdwr_stall", 32'(bus2.stall), 32'd0);
        checkVal("rdwr_valid", 32'(bus2.out_valid), 32'd1);
        checkVal("rdwr_load", bus2.out_load_data, 32'd0);
        load2("rdwr_mem", 2'b10, 1'b0, 32'h50, 32'h00000077);

        // debug mode suppresses the store but still retires it
        store2(2'b10, 32'h14, 32'h12345678);
        bus2.debug_on = 1'b1;
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h14, 32'hDEADBEEF, 5'd2, 5'h03);
        tick();
        bubble(1'b0);
        checkVal("dbg_st_valid", 32'(bus2.out_valid), 32'd1);
        bus2.debug_on = 1'b0;
        bus2.debug_addr = 10'd5;
        tick();
        checkVal("dbg_port", bus2.out_mem_debug, 32'h12345678);
        load2("dbg_mem", 2'b10, 1'b0, 32'h14, 32'h12345678);

        // misaligned word store
        store2(2'b10, 32'h20, 32'h01020304);
        drive(1'b0, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h22, 32'h99887766, 5'd2, 5'h03);
        tick();
        bubble(1'b0);
        checkVal("mis_valid", 32'(bus2.out_valid), 32'd1);
`ifdef MEM_ACCESS_MISALIGN_TRAP_EN
        checkVal("mis_flag", 32'(bus2.misalign), 32'd1);
        checkVal("mis_wb", 32'(bus2.out_wb), 32'd0);
        load2("mis_mem", 2'b10, 1'b0, 32'h20, 32'h01020304);
`else
        checkVal("mis_flag", 32'(bus2.misalign), 32'd0);
        checkVal("mis_wb", 32'(bus2.out_wb), 32'h03);
        load2("mis_mem", 2'b10, 1'b0, 32'h20, 32'h99887766);
`endif

        // dut3: freeze for three cycles during WAIT
        drive(1'b1, 1'b1, 1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'hCAFEF00D, 5'd2, 5'h03);
        tick();
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0, 5'd9, 5'h0A);
        tick();
        bubble(1'b1);
        checkVal("frz_stall0", 32'(bus3.stall), 32'd1);
        bus3.stop_debug = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checkVal("frz_hold_stall", 32'(bus3.stall), 32'd1);
            checkVal("frz_hold_valid", 32'(bus3.out_valid), 32'd0);
            checkVal("frz_hold_alu", bus3.out_alu_result, 32'h8);
        end
        bus3.stop_debug = 1'b0;
        tick();
        checkVal("frz_late_stall", 32'(bus3.stall), 32'd1);
        checkVal("frz_late_valid", 32'(bus3.out_valid), 32'd0);
        tick();
        checkVal("frz_done_valid", 32'(bus3.out_valid), 32'd1);
        checkVal("frz_done_data", bus3.out_load_data, 32'hCAFEF00D);
        checkVal("frz_done_stall", 32'(bus3.stall), 32'd0);
        tick();

        // dut3: reset in the middle of WAIT aborts the load
        drive(1'b1, 1'b1, 1'b1, 1'b0, 2'b10, 1'b0, 32'h8, 32'd0, 5'd9, 5'h0A);
        tick();
        bubble(1'b1);
        checkVal("rw_stall_pre", 32'(bus3.stall), 32'd1);
        checkVal("rw_alu_pre", bus3.out_alu_result, 32'h8);
        #3;
        rst3 = 1'b1;
        #1;
        checkVal("rw_stall", 32'(bus3.stall), 32'd0);
        checkVal("rw_valid", 32'(bus3.out_valid), 32'd0);
        checkVal("rw_alu", bus3.out_alu_result, 32'd0);
        checkVal("rw_wreg", 32'(bus3.out_wreg), 32'd0);
        checkVal("rw_load", bus3.out_load_data, 32'd0);
        tick();
        rst3 = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            checkVal("rw_after_valid", 32'(bus3.out_valid), 32'd0);
            checkVal("rw_after_stall", 32'(bus3.stall), 32'd0);
        end

        $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
        $finish;
    end
endmodule
